// File: rtl/alu.sv
// 32-bit ALU with combinational result/flags and a registered copy of them.
// Ops: add, sub, sll, slt, sltu, xor, srl, sra, or, and; encodings 10..15 yield zero.
module alu (
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [3:0]  op,
    output logic [31:0] result,
    output logic        negative,
    output logic        zero,
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] result_q,
    output logic        negative_q,
    output logic        zero_q
);

    localparam int unsigned W   = 32;
    localparam int unsigned SHW = 5;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;

    logic [SHW-1:0] shamt;
    logic [W-1:0]   result_d;
    logic           negative_d;
    logic           zero_d;

    // Only the low five bits of operand B steer the shifters.
    assign shamt = in2[SHW-1:0];

    // Operation decode; unused encodings fall through to zero.
    always_comb begin
        result_d = '0;
        unique case (op)
            OP_ADD:  result_d = W'(in1 + in2);
            OP_SUB:  result_d = W'(in1 - in2);
            OP_SLL:  result_d = W'(in1 << shamt);
            OP_SLT:  result_d = W'({(W-1)'(0), ($signed(in1) < $signed(in2))});
            OP_SLTU: result_d = W'({(W-1)'(0), (in1 < in2)});
            OP_XOR:  result_d = in1 ^ in2;
            OP_SRL:  result_d = W'(in1 >> shamt);
            OP_SRA:  result_d = W'($signed(in1) >>> shamt);
            OP_OR:   result_d = in1 | in2;
            OP_AND:  result_d = in1 & in2;
            default: result_d = '0;
        endcase
    end

    // Flags follow the final result for every op.
    always_comb begin
        negative_d = result_d[W-1];
        zero_d     = (result_d == '0);
    end

    assign result   = result_d;
    assign negative = negative_d;
    assign zero     = zero_d;

    // Registered copy; reset clears to the value of a zero result.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q   <= '0;
            negative_q <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            result_q   <= result_d;
            negative_q <= negative_d;
            zero_q     <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, reset behaviour and random ops
// compared against an arithmetic reference model.
module tb_alu;

    logic [31:0] in1, in2;
    logic [3:0]  op;
    logic [31:0] result, result_q;
    logic        negative, zero, negative_q, zero_q;
    logic        clk, reset;

    int total = 0;
    int bad   = 0;

    alu dut (
        .in1(in1), .in2(in2), .op(op),
        .result(result), .negative(negative), .zero(zero),
        .clk(clk), .reset(reset),
        .result_q(result_q), .negative_q(negative_q), .zero_q(zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each op computed directly from its arithmetic definition.
    function automatic logic [31:0] ref_res(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [63:0] ext;
        sh  = b % 32;
        ext = {{32{a[31]}}, a};
        case (o)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return 32'(64'(a) * (64'd1 << sh));
            4'd3: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd4: return (a < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return 32'(64'(a) / (64'd1 << sh));
            4'd7: return ext[sh +: 32];
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one op, check comb outputs, clock it, check registered copy.
    task automatic run(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e;
        e   = ref_res(o, a, b);
        op  = o; in1 = a; in2 = b;
        #1;
        check({tag, ".res"}, result, e);
        check({tag, ".neg"}, 32'(negative), 32'(e[31]));
        check({tag, ".zero"}, 32'(zero), 32'(e == 32'd0));
        @(posedge clk); #1;
        check({tag, ".res_q"}, result_q, e);
        check({tag, ".neg_q"}, 32'(negative_q), 32'(e[31]));
        check({tag, ".zero_q"}, 32'(zero_q), 32'(e == 32'd0));
    endtask

    task automatic expect_val(input string tag, input logic [3:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] e);
        op = o; in1 = a; in2 = b;
        #1;
        check(tag, result, e);
    endtask

    initial begin
        reset = 1'b1; op = 4'd1; in1 = 32'd0; in2 = 32'd1;
        @(posedge clk); #1;
        // Reset clears registers but leaves comb path live.
        check("rst.res_q", result_q, 32'd0);
        check("rst.neg_q", 32'(negative_q), 32'd0);
        check("rst.zero_q", 32'(zero_q), 32'd1);
        check("rst.comb", result, 32'hFFFF_FFFF);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rel.res_q", result_q, 32'hFFFF_FFFF);
        check("rel.neg_q", 32'(negative_q), 32'd1);
        check("rel.zero_q", 32'(zero_q), 32'd0);

        // Directed vectors with hand-derived expectations.
        expect_val("add1", 4'd0, 32'h000F, 32'h00F0, 32'h0000_00FF);
        expect_val("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        check("add_wrap.z", 32'(zero), 32'd1);
        expect_val("sub_wrap", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF);
        check("sub_wrap.n", 32'(negative), 32'd1);
        expect_val("sub_eq", 4'd1, 32'h110, 32'h110, 32'd0);
        expect_val("and", 4'd9, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00);
        expect_val("or", 4'd8, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFF0F_FF0F);
        check("or.n", 32'(negative), 32'd1);
        expect_val("xor1", 4'd5, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555);
        expect_val("xor2", 4'd5, 32'h1100, 32'h1010, 32'h0110);
        expect_val("sll", 4'd2, 32'hF, 32'd4, 32'hF0);
        expect_val("srl", 4'd6, 32'hF0, 32'd4, 32'hF);
        expect_val("sra_pos", 4'd7, 32'd16, 32'd2, 32'd4);
        expect_val("sra_neg", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
        expect_val("sra31", 4'd7, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
        expect_val("srl31", 4'd6, 32'h8000_0000, 32'd31, 32'd1);
        expect_val("sll31", 4'd2, 32'd1, 32'd31, 32'h8000_0000);
        expect_val("sll0", 4'd2, 32'h1234_5678, 32'd0, 32'h1234_5678);
        expect_val("sll_mask", 4'd2, 32'hF, 32'h24, 32'hF0);
        expect_val("slt1", 4'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1);
        expect_val("slt0", 4'd3, 32'h00FF, 32'hFFFF_FFFF, 32'd0);
        check("slt0.z", 32'(zero), 32'd1);
        expect_val("sltu1", 4'd4, 32'h00FF, 32'hFFFF_FFFF, 32'd1);
        check("sltu1.z", 32'(zero), 32'd0);
        expect_val("sltu0", 4'd4, 32'hFFFF_FFFF, 32'h00FF, 32'd0);
        for (int k = 10; k < 16; k++) begin
            expect_val("undef", 4'(k), 32'hDEAD_BEEF, 32'h8000_0001, 32'd0);
            check("undef.z", 32'(zero), 32'd1);
            check("undef.n", 32'(negative), 32'd0);
        end

        // Registered path, then reset mid-stream clears on that edge.
        run("seq_sub", 4'd1, 32'd0, 32'd1);
        op = 4'd0; in1 = 32'h8000_0000; in2 = 32'h1; reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst.res_q", result_q, 32'd0);
        check("mid_rst.zero_q", 32'(zero_q), 32'd1);
        check("mid_rst.neg_q", 32'(negative_q), 32'd0);
        check("mid_rst.comb", result, 32'h8000_0001);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst.res_q", result_q, 32'h8000_0001);

        // Random ops against the model.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if (i % 7 == 0) b = b & 32'h1F;
            if (i % 11 == 0) a = b;
            run("rand", 4'($urandom_range(0, 15)), a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all registered state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in1  input  32  operand A.
REQ-005 in2  input  32  operand B; for shifts, in2[4:0] is the shift amount.
REQ-006 op  input  4  operation select.
REQ-007 result  output  32  combinational operation result.
REQ-008 negative  output  1  combinational; equals result[31].
REQ-009 zero  output  1  combinational; 1 when result == 32'h0.
REQ-010 result_q  output  32  registered copy of result.
REQ-011 negative_q  output  1  registered copy of negative.
REQ-012 zero_q  output  1  registered copy of zero.
REQ-013 Port declaration order SHALL be in1, in2, op, result, negative, zero, clk, reset, result_q, negative_q, zero_q, so that positional connection of the first six ports is valid.

Function
REQ-014 result, negative and zero SHALL be purely combinational functions of in1, in2 and op, with zero clock latency and no dependence on clk or reset.
REQ-015 op 4'b0000 (add) SHALL produce in1 + in2 modulo 2^32; carry-out is discarded (FFFFFFFF + 1 = 0).
REQ-016 op 4'b0001 (sub) SHALL produce in1 - in2 modulo 2^32 (0 - 1 = FFFFFFFF).
REQ-017 op 4'b0010 (sll) SHALL produce in1 << in2[4:0], zero-filled; in2[31:5] is ignored.
REQ-018 op 4'b0011 (slt) SHALL produce 32'd1 if $signed(in1) < $signed(in2), else 32'd0.
REQ-019 op 4'b0100 (sltu) SHALL produce 32'd1 if unsigned in1 < unsigned in2, else 32'd0.
REQ-020 op 4'b0101 (xor) SHALL produce in1 ^ in2.
REQ-021 op 4'b0110 (srl) SHALL produce in1 >> in2[4:0], zero-filled.
REQ-022 op 4'b0111 (sra) SHALL produce in1 arithmetically shifted right by in2[4:0], sign-filled from in1[31].
REQ-023 op 4'b1000 (or) SHALL produce in1 | in2.
REQ-024 op 4'b1001 (and) SHALL produce in1 & in2.
REQ-025 op values 4'b1010 through 4'b1111 SHALL produce result 32'h0, so zero = 1 and negative = 0.
REQ-026 negative and zero SHALL be derived from the final result for every op; for slt and sltu, negative is always 0 and zero = ~result[0].
REQ-027 A shift amount of 0 SHALL return in1 unchanged; a shift amount of 31 SHALL be fully supported.
REQ-028 When reset is low, on each rising edge of clk, result_q, negative_q and zero_q SHALL capture result, negative and zero (1-cycle latency).
REQ-029 The outputs SHALL contain no latches and SHALL never be X for any known input combination.

Reset
REQ-030 When reset is high on a rising edge of clk, result_q SHALL become 32'h0, negative_q 0 and zero_q 1.
REQ-031 reset SHALL take priority over capture, and SHALL NOT affect the combinational outputs result, negative and zero.
REQ-032 When reset is deasserted, the first capture SHALL occur on the next rising edge of clk.

Verification
REQ-033 Arithmetic: add 000F+00F0 -> 000000FF, n=0, z=0; add FFFFFFFF+1 -> 0, z=1; sub 0-1 -> FFFFFFFF, n=1; sub 110-110 -> 0, z=1.
REQ-034 Logic: and FF00FF00,0F0F0F0F -> 0F000F00; or of the same operands -> FF0FFF0F, n=1; xor AAAAAAAA,FFFFFFFF -> 55555555; xor 1100,1010 -> 0110.
REQ-035 Shifts: sll F by 4 -> F0; srl F0 by 4 -> F; sra 16 by 2 -> 4; sra FFFFFFFF by 1 -> FFFFFFFF, n=1; sll with in2 = 32'h24 -> shift by 4.
REQ-036 Compares: slt FFFFFFFE,FFFFFFFF -> 1; slt 00FF,FFFFFFFF -> 0, z=1; sltu 00FF,FFFFFFFF -> 1; sltu FFFFFFFF,00FF -> 0, z=1.
REQ-037 Registered path and reset: assert reset for one edge -> result_q=0, negative_q=0, zero_q=1; release reset, apply sub 0-1 -> after one edge result_q=FFFFFFFF, negative_q=1, zero_q=0; assert reset mid-stream -> values cleared on that edge.
REQ-038 Undefined ops: op 4'b1010..4'b1111 with arbitrary operands -> result 0, zero 1, negative 0.
